dispatch_stage: RTL and testbench
=================================

Name: dispatch_stage

Overview:
- Sits directly downstream of rename.
- Accepts one renamed instruction per cycle over valid/ready.
- Looks up operand readiness in a physical-register busy table, then issues the instruction to the ROB and to exactly one issue queue (ALU, LSU, BR).
- Registered single-entry output stage; squashes its contents on misprediction recovery.

Parameters:
- N_PHYS, 64, number of physical registers; PW = $clog2(N_PHYS)
- ROB_TAG_W, 6, ROB tag width
- N_WB, 2, number of writeback wakeup ports

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ren_valid_i  in  1  renamed instruction valid
- ren_ready_o  out  1  dispatch can accept
- rs1_p_i, rs2_p_i  in  PW  source pregs
- rs1_used_i, rs2_used_i  in  1  source used
- rd_new_p_i, rd_old_p_i  in  PW  new/old dest preg
- rd_used_i  in  1  writes a dest (rd != x0)
- rob_tag_i  in  ROB_TAG_W  tag from rename
- fu_type_i  in  2  fu_type_t: 0 ALU, 1 LSU, 2 BR, 3 illegal (routed to ALU)
- rob_valid_o / rob_ready_i  out/in  1  ROB allocation handshake
- rob_tag_o, rob_rd_new_o, rob_rd_old_o, rob_rd_used_o  out  ROB entry fields
- iq_valid_o  out  3  one-hot per queue (bit = fu_type)
- iq_ready_i  in  3  per-queue ready
- iq_rs1_p_o, iq_rs2_p_o, iq_rd_p_o  out  PW  operands to queue
- iq_rs1_rdy_o, iq_rs2_rdy_o  out  1  operand ready at dispatch
- iq_rob_tag_o  out  ROB_TAG_W
- wb_valid_i  in  N_WB  writeback wakeup valid
- wb_preg_i  in  N_WB*PW  wakeup preg
- recover_i  in  1  misprediction flush

Behaviour:
- Reset:
  - out_valid_q=0, so rob_valid_o=0 and iq_valid_o=0.
  - All output data fields = 0.
  - Busy table all 0 (all pregs ready).
- Output stage:
  - ren_ready_o = (!out_valid_q || fire) && !recover_i.
  - fire = out_valid_q && rob_ready_i && iq_ready_i[sel].
  - Fire is all-or-nothing: ROB and the selected IQ complete the handshake in the same cycle.
  - Neither rob_valid_o nor iq_valid_o may drop until fire.
  - Data stays stable while valid && !fire.
- Latency: an instruction accepted in cycle N is presented in cycle N+1. Back-to-back throughput is 1/cycle when downstream is ready.
- Readiness at accept (combinational into the register):
  - rdy = !used || preg==0 || (!busy[preg] && no same-cycle busy-set hazard) || wakeup match on any wb port this cycle.
  - Wakeup bypass takes priority over busy.
- Presented-but-stalled entry: the registered rs*_rdy bits are updated each cycle they match a wakeup, so a stalled entry never misses a wakeup.
- Busy table:
  - On accept with rd_used_i && rd_new_p_i!=0, set busy[rd_new_p_i].
  - On wb_valid_i[k], clear busy[wb_preg_i[k]].
  - Same-cycle set and clear of the same preg: set wins (new allocation).
  - Preg 0 is never busy; writes to 0 are ignored.
- Recovery:
  - recover_i=1 clears out_valid_q that cycle, even if fire would occur; fire is suppressed.
  - No accept while recover_i.
  - Busy table is not restored; squashed pregs are re-set on reallocation.
- fu_type 3 is routed to ALU (illegal-op trap handled in ALU path).
- Reset asserted mid-handshake drops the entry without fire.

Optional Feature:
- DISPATCH_STATS_EN:
  - When defined, adds 32-bit saturating counters: stall_rob_cnt (valid && !rob_ready_i), stall_iq_cnt[3] (valid && rob_ready_i && !iq_ready_i[sel]), dispatched_cnt (fire).
  - Counters are exposed as output ports stats_*_o, reset to 0, and do not count during recover_i.
  - When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- pipeline_types package gets fu_type_t, FU_ALU/FU_LSU/FU_BR constants, and a dispatch_payload_t struct (pregs, rdy bits, tag).
- Sub-module busy_table: N_PHYS-bit register with a set port, N_WB clear ports, and 2 read ports with wakeup bypass.

Test Plan:
- Reset, then a single ALU op (rs1=5, rs2=6, rd_new=40): presented next cycle with iq_valid_o=001 and both rdy=1; busy[40]=1 after accept.
- Dependent op rs1=40 dispatched while busy → iq_rs1_rdy_o=0; later wb_preg=40 while stalled with iq_ready_i=0 → rdy becomes 1 before fire.
- Wakeup of preg 40 in the same cycle as accept of a consumer of 40 → iq_rs1_rdy_o=1.
- rob_ready_i=1, iq_ready_i[LSU]=0 for 3 cycles on an LSU op → no fire, outputs stable, ren_ready_o=0; fire on cycle 4.
- recover_i with a valid BR entry stalled → valid cleared next cycle, ROB never sees fire, ren_ready_o=0 during recover.
- rd_used_i with rd_new=0 → busy table unchanged; consumer of preg 0 is always ready.

Source files
------------

// File: rtl/dispatch_stage_pkg.sv
// Shared dispatch types: functional-unit codes, default widths and the
// registered payload carried by the single-entry output stage.
package pipeline_types;

  localparam int DEF_N_PHYS    = 64;
  localparam int DEF_PW        = $clog2(DEF_N_PHYS);
  localparam int DEF_ROB_TAG_W = 6;
  localparam int DEF_N_WB      = 2;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_LSU = 2'd1,
    FU_BR  = 2'd2,
    FU_ILL = 2'd3
  } fu_type_t;

  typedef struct packed {
    logic [DEF_PW-1:0]        rs1_p;
    logic [DEF_PW-1:0]        rs2_p;
    logic [DEF_PW-1:0]        rd_p;
    logic [DEF_PW-1:0]        rd_old_p;
    logic                     rd_used;
    logic                     rs1_rdy;
    logic                     rs2_rdy;
    logic [DEF_ROB_TAG_W-1:0] rob_tag;
    fu_type_t                 fu;
  } dispatch_payload_t;

  // Illegal ops travel down the ALU path, which raises the trap.
  function automatic fu_type_t route_fu(input logic [1:0] f);
    return (f == FU_ILL) ? FU_ALU : fu_type_t'(f);
  endfunction

endpackage

// File: rtl/dispatch_stage_busy_table.sv
// Physical-register busy table: one set port (new allocation), N_WB clear
// ports (writeback) and two source read ports with same-cycle wakeup bypass.
module busy_table
  import pipeline_types::*;
#(
  parameter int N_PHYS = DEF_N_PHYS,
  parameter int N_WB   = DEF_N_WB,
  localparam int PW    = $clog2(N_PHYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [PW-1:0]        set_preg,
  input  logic [N_WB-1:0]      wb_valid,
  input  logic [N_WB*PW-1:0]   wb_preg,
  input  logic [1:0][PW-1:0]   rd_preg,
  input  logic [1:0]           rd_used,
  output logic [1:0]           rd_rdy
);

  logic [N_PHYS-1:0] busy_q;
  logic [N_PHYS-1:0] busy_next;

  // Clears first, then the set, so a new allocation beats a stale writeback.
  always_comb begin
    busy_next = busy_q;
    for (int k = 0; k < N_WB; k++) begin
      if (wb_valid[k]) busy_next[wb_preg[k*PW +: PW]] = 1'b0;
    end
    if (set_en) busy_next[set_preg] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_next;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_read
    logic wake;
    always_comb begin
      wake = 1'b0;
      for (int k = 0; k < N_WB; k++) begin
        if (wb_valid[k] && wb_preg[k*PW +: PW] == rd_preg[gi]) wake = 1'b1;
      end
      rd_rdy[gi] = !rd_used[gi] || (rd_preg[gi] == '0) || wake ||
                   (!busy_q[rd_preg[gi]] && !(set_en && set_preg == rd_preg[gi]));
    end
  end

endmodule

// File: rtl/dispatch_stage.sv
// Dispatch stage: single registered entry feeding the ROB and one issue queue.
// Optional DISPATCH_STATS_EN adds saturating stall/dispatch counters.
module dispatch_stage
  import pipeline_types::*;
#(
  parameter int N_PHYS    = DEF_N_PHYS,
  parameter int ROB_TAG_W = DEF_ROB_TAG_W,
  parameter int N_WB      = DEF_N_WB,
  localparam int PW       = $clog2(N_PHYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ren_valid_i,
  output logic                 ren_ready_o,
  input  logic [PW-1:0]        rs1_p_i,
  input  logic [PW-1:0]        rs2_p_i,
  input  logic                 rs1_used_i,
  input  logic                 rs2_used_i,
  input  logic [PW-1:0]        rd_new_p_i,
  input  logic [PW-1:0]        rd_old_p_i,
  input  logic                 rd_used_i,
  input  logic [ROB_TAG_W-1:0] rob_tag_i,
  input  logic [1:0]           fu_type_i,
  output logic                 rob_valid_o,
  input  logic                 rob_ready_i,
  output logic [ROB_TAG_W-1:0] rob_tag_o,
  output logic [PW-1:0]        rob_rd_new_o,
  output logic [PW-1:0]        rob_rd_old_o,
  output logic                 rob_rd_used_o,
  output logic [2:0]           iq_valid_o,
  input  logic [2:0]           iq_ready_i,
  output logic [PW-1:0]        iq_rs1_p_o,
  output logic [PW-1:0]        iq_rs2_p_o,
  output logic [PW-1:0]        iq_rd_p_o,
  output logic                 iq_rs1_rdy_o,
  output logic                 iq_rs2_rdy_o,
  output logic [ROB_TAG_W-1:0] iq_rob_tag_o,
  input  logic [N_WB-1:0]      wb_valid_i,
  input  logic [N_WB*PW-1:0]   wb_preg_i,
`ifdef DISPATCH_STATS_EN
  output logic [31:0]          stats_stall_rob_o,
  output logic [2:0][31:0]     stats_stall_iq_o,
  output logic [31:0]          stats_dispatched_o,
`endif
  input  logic                 recover_i
);

  logic              out_valid_q;
  dispatch_payload_t out_q;
  dispatch_payload_t in_payload;
  logic              sel_ready;
  logic              fire;
  logic              accept;
  logic [1:0]        src_rdy;
  logic              wake_rs1;
  logic              wake_rs2;

  always_comb begin
    case (out_q.fu)
      FU_LSU:  sel_ready = iq_ready_i[1];
      FU_BR:   sel_ready = iq_ready_i[2];
      default: sel_ready = iq_ready_i[0];
    endcase
  end

  // ROB and the selected queue must both take the entry in the same cycle.
  assign fire        = out_valid_q && rob_ready_i && sel_ready && !recover_i;
  assign ren_ready_o = (!out_valid_q || fire) && !recover_i;
  assign accept      = ren_valid_i && ren_ready_o;

  busy_table #(.N_PHYS(N_PHYS), .N_WB(N_WB)) u_busy (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept && rd_used_i),
    .set_preg (rd_new_p_i),
    .wb_valid (wb_valid_i),
    .wb_preg  (wb_preg_i),
    .rd_preg  ({rs2_p_i, rs1_p_i}),
    .rd_used  ({rs2_used_i, rs1_used_i}),
    .rd_rdy   (src_rdy)
  );

  always_comb begin
    in_payload          = '0;
    in_payload.rs1_p    = rs1_p_i;
    in_payload.rs2_p    = rs2_p_i;
    in_payload.rd_p     = rd_new_p_i;
    in_payload.rd_old_p = rd_old_p_i;
    in_payload.rd_used  = rd_used_i;
    in_payload.rs1_rdy  = src_rdy[0];
    in_payload.rs2_rdy  = src_rdy[1];
    in_payload.rob_tag  = rob_tag_i;
    in_payload.fu       = route_fu(fu_type_i);
  end

  // A stalled entry keeps listening to writebacks so it never misses one.
  always_comb begin
    wake_rs1 = 1'b0;
    wake_rs2 = 1'b0;
    for (int k = 0; k < N_WB; k++) begin
      if (wb_valid_i[k] && wb_preg_i[k*PW +: PW] == out_q.rs1_p) wake_rs1 = 1'b1;
      if (wb_valid_i[k] && wb_preg_i[k*PW +: PW] == out_q.rs2_p) wake_rs2 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (recover_i) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_q       <= in_payload;
    end else if (fire) begin
      out_valid_q <= 1'b0;
    end else if (out_valid_q) begin
      out_q.rs1_rdy <= out_q.rs1_rdy | wake_rs1;
      out_q.rs2_rdy <= out_q.rs2_rdy | wake_rs2;
    end
  end

  assign rob_valid_o   = out_valid_q;
  assign rob_tag_o     = out_q.rob_tag;
  assign rob_rd_new_o  = out_q.rd_p;
  assign rob_rd_old_o  = out_q.rd_old_p;
  assign rob_rd_used_o = out_q.rd_used;
  assign iq_valid_o    = out_valid_q ? 3'(3'b001 << out_q.fu) : 3'b000;
  assign iq_rs1_p_o    = out_q.rs1_p;
  assign iq_rs2_p_o    = out_q.rs2_p;
  assign iq_rd_p_o     = out_q.rd_p;
  assign iq_rs1_rdy_o  = out_q.rs1_rdy;
  assign iq_rs2_rdy_o  = out_q.rs2_rdy;
  assign iq_rob_tag_o  = out_q.rob_tag;

`ifdef DISPATCH_STATS_EN
  logic [2:0] iq_stall;

  for (genvar gi = 0; gi < 3; gi++) begin : g_iq_stall
    assign iq_stall[gi] = out_valid_q && rob_ready_i && !iq_ready_i[gi] &&
                          (out_q.fu == fu_type_t'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stats_stall_rob_o  <= '0;
      stats_stall_iq_o   <= '0;
      stats_dispatched_o <= '0;
    end else if (!recover_i) begin
      if (out_valid_q && !rob_ready_i && stats_stall_rob_o != '1)
        stats_stall_rob_o <= stats_stall_rob_o + 32'd1;
      for (int q = 0; q < 3; q++) begin
        if (iq_stall[q] && stats_stall_iq_o[q] != '1)
          stats_stall_iq_o[q] <= stats_stall_iq_o[q] + 32'd1;
      end
      if (fire && stats_dispatched_o != '1)
        stats_dispatched_o <= stats_dispatched_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_stage.sv
// Bench for dispatch_stage: directed scenarios then random traffic, all
// checked against a behavioural model of the busy table and output entry.
module tb_dispatch_stage;

  localparam int PW  = 6;
  localparam int TW  = 6;
  localparam int NWB = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            ren_valid_i, ren_ready_o;
  logic [PW-1:0]   rs1_p_i, rs2_p_i, rd_new_p_i, rd_old_p_i;
  logic            rs1_used_i, rs2_used_i, rd_used_i;
  logic [TW-1:0]   rob_tag_i;
  logic [1:0]      fu_type_i;
  logic            rob_valid_o, rob_ready_i;
  logic [TW-1:0]   rob_tag_o, iq_rob_tag_o;
  logic [PW-1:0]   rob_rd_new_o, rob_rd_old_o;
  logic            rob_rd_used_o;
  logic [2:0]      iq_valid_o, iq_ready_i;
  logic [PW-1:0]   iq_rs1_p_o, iq_rs2_p_o, iq_rd_p_o;
  logic            iq_rs1_rdy_o, iq_rs2_rdy_o;
  logic [NWB-1:0]  wb_valid_i;
  logic [NWB*PW-1:0] wb_preg_i;
  logic            recover_i;
`ifdef DISPATCH_STATS_EN
  logic [31:0]      stats_stall_rob_o, stats_dispatched_o;
  logic [2:0][31:0] stats_stall_iq_o;
`endif

  always #5 clk = ~clk;

  dispatch_stage dut (
    .clk(clk), .rst(rst),
    .ren_valid_i(ren_valid_i), .ren_ready_o(ren_ready_o),
    .rs1_p_i(rs1_p_i), .rs2_p_i(rs2_p_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
    .rd_new_p_i(rd_new_p_i), .rd_old_p_i(rd_old_p_i), .rd_used_i(rd_used_i),
    .rob_tag_i(rob_tag_i), .fu_type_i(fu_type_i),
    .rob_valid_o(rob_valid_o), .rob_ready_i(rob_ready_i),
    .rob_tag_o(rob_tag_o), .rob_rd_new_o(rob_rd_new_o),
    .rob_rd_old_o(rob_rd_old_o), .rob_rd_used_o(rob_rd_used_o),
    .iq_valid_o(iq_valid_o), .iq_ready_i(iq_ready_i),
    .iq_rs1_p_o(iq_rs1_p_o), .iq_rs2_p_o(iq_rs2_p_o), .iq_rd_p_o(iq_rd_p_o),
    .iq_rs1_rdy_o(iq_rs1_rdy_o), .iq_rs2_rdy_o(iq_rs2_rdy_o),
    .iq_rob_tag_o(iq_rob_tag_o),
    .wb_valid_i(wb_valid_i), .wb_preg_i(wb_preg_i),
`ifdef DISPATCH_STATS_EN
    .stats_stall_rob_o(stats_stall_rob_o), .stats_stall_iq_o(stats_stall_iq_o),
    .stats_dispatched_o(stats_dispatched_o),
`endif
    .recover_i(recover_i)
  );

  // Reference state: which pregs await a writeback, and the presented entry.
  bit   busy_m [64];
  bit   mv;
  int   m_fu, m_rs1, m_rs2, m_rd, m_rdold, m_tag;
  bit   m_rdused, m_r1, m_r2;
  int   n_err = 0;
  int   n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit wb_hit(input int p);
    for (int k = 0; k < NWB; k++)
      if (wb_valid_i[k] && int'(wb_preg_i[k*PW +: PW]) == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit src_ready(input bit used, input int p, input bit setting, input int setp);
    return !used || p == 0 || wb_hit(p) || (!busy_m[p] && !(setting && setp == p));
  endfunction

  // One clock: check handshake, advance the model across the edge, check outputs.
  task automatic cycle();
    bit m_fire, exp_rdy, acc, setting, n_r1, n_r2;
    #1;
    m_fire  = mv && rob_ready_i && iq_ready_i[m_fu] && !recover_i;
    exp_rdy = (!mv || m_fire) && !recover_i;
    chk("ren_ready", 64'(ren_ready_o), 64'(exp_rdy));
    acc     = ren_valid_i && exp_rdy;
    setting = acc && rd_used_i && rd_new_p_i != 0;
    n_r1 = src_ready(rs1_used_i, int'(rs1_p_i), setting, int'(rd_new_p_i));
    n_r2 = src_ready(rs2_used_i, int'(rs2_p_i), setting, int'(rd_new_p_i));
    if (m_fire && !rst) $display("dispatch tag=%0d fu=%0d rs1=%0d/%0b rs2=%0d/%0b rd=%0d",
                                 m_tag, m_fu, m_rs1, m_r1, m_rs2, m_r2, m_rd);
    @(posedge clk);
    if (rst) begin
      mv = 0; m_fu = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_rdold = 0; m_tag = 0;
      m_rdused = 0; m_r1 = 0; m_r2 = 0;
      foreach (busy_m[i]) busy_m[i] = 0;
    end else begin
      if (recover_i) mv = 0;
      else if (acc) begin
        mv = 1; m_fu = (fu_type_i == 2'd3) ? 0 : int'(fu_type_i);
        m_rs1 = int'(rs1_p_i); m_rs2 = int'(rs2_p_i); m_rd = int'(rd_new_p_i);
        m_rdold = int'(rd_old_p_i); m_rdused = rd_used_i; m_tag = int'(rob_tag_i);
        m_r1 = n_r1; m_r2 = n_r2;
      end else if (m_fire) mv = 0;
      else if (mv) begin
        m_r1 = m_r1 | wb_hit(m_rs1);
        m_r2 = m_r2 | wb_hit(m_rs2);
      end
      for (int k = 0; k < NWB; k++)
        if (wb_valid_i[k]) busy_m[int'(wb_preg_i[k*PW +: PW])] = 0;
      if (setting) busy_m[int'(rd_new_p_i)] = 1;
    end
    #1;
    chk("rob_valid", 64'(rob_valid_o), 64'(mv));
    chk("iq_valid", 64'(iq_valid_o), mv ? 64'(1 << m_fu) : 64'd0);
    if (mv) begin
      chk("rob_tag", 64'(rob_tag_o), 64'(m_tag));
      chk("iq_rob_tag", 64'(iq_rob_tag_o), 64'(m_tag));
      chk("rd_new", 64'(rob_rd_new_o), 64'(m_rd));
      chk("rd_old", 64'(rob_rd_old_o), 64'(m_rdold));
      chk("rd_used", 64'(rob_rd_used_o), 64'(m_rdused));
      chk("iq_rd", 64'(iq_rd_p_o), 64'(m_rd));
      chk("iq_rs1", 64'(iq_rs1_p_o), 64'(m_rs1));
      chk("iq_rs2", 64'(iq_rs2_p_o), 64'(m_rs2));
      chk("rs1_rdy", 64'(iq_rs1_rdy_o), 64'(m_r1));
      chk("rs2_rdy", 64'(iq_rs2_rdy_o), 64'(m_r2));
    end
  endtask

  task automatic drive_op(input bit v, input int fu, input int rs1, input bit u1,
                          input int rs2, input bit u2, input int rd, input int rdold,
                          input bit ru, input int tag);
    ren_valid_i = v; fu_type_i = 2'(fu);
    rs1_p_i = PW'(rs1); rs1_used_i = u1; rs2_p_i = PW'(rs2); rs2_used_i = u2;
    rd_new_p_i = PW'(rd); rd_old_p_i = PW'(rdold); rd_used_i = ru; rob_tag_i = TW'(tag);
  endtask

  task automatic set_down(input bit rr, input logic [2:0] iqr);
    rob_ready_i = rr; iq_ready_i = iqr;
  endtask

  task automatic set_wb(input logic [1:0] v, input int p0, input int p1);
    wb_valid_i = v; wb_preg_i = {PW'(p1), PW'(p0)};
  endtask

  initial begin
    rst = 1'b1; recover_i = 1'b0;
    drive_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_down(0, 3'b000); set_wb(2'b00, 0, 0);
    mv = 0; m_fu = 0;
    cycle(); cycle();
    chk("rst_rob_tag", 64'(rob_tag_o), 64'd0);
    chk("rst_iq_rs1", 64'(iq_rs1_p_o), 64'd0);
    chk("rst_iq_rd", 64'(iq_rd_p_o), 64'd0);
    chk("rst_rs1_rdy", 64'(iq_rs1_rdy_o), 64'd0);
    rst = 1'b0;

    // Single ALU op, no dependencies.
    drive_op(1, 0, 5, 1, 6, 1, 40, 3, 1, 1); set_down(1, 3'b111);
    cycle();
    chk("t1_iq_valid", 64'(iq_valid_o), 64'b001);
    chk("t1_rs1_rdy", 64'(iq_rs1_rdy_o), 64'd1);
    chk("t1_rs2_rdy", 64'(iq_rs2_rdy_o), 64'd1);

    // Consumer of 40 sees it busy, then wakes up while stalled.
    drive_op(1, 0, 40, 1, 5, 1, 41, 4, 1, 2);
    cycle();
    chk("t2_dep_rdy", 64'(iq_rs1_rdy_o), 64'd0);
    drive_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); set_down(1, 3'b000);
    cycle();
    chk("t2_stall_rdy", 64'(iq_rs1_rdy_o), 64'd0);
    set_wb(2'b01, 40, 0);
    cycle();
    chk("t2_wake_rdy", 64'(iq_rs1_rdy_o), 64'd1);
    chk("t2_still_valid", 64'(rob_valid_o), 64'd1);
    set_wb(2'b00, 0, 0); set_down(1, 3'b111);
    cycle();
    chk("t2_fired", 64'(rob_valid_o), 64'd0);

    // Wakeup in the same cycle as the consumer is accepted.
    drive_op(1, 0, 7, 1, 8, 1, 42, 5, 1, 3);
    cycle();
    drive_op(1, 0, 42, 1, 0, 0, 43, 6, 1, 4); set_wb(2'b10, 0, 42);
    cycle();
    chk("t3_bypass_rdy", 64'(iq_rs1_rdy_o), 64'd1);
    drive_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); set_wb(2'b00, 0, 0);
    cycle();

    // LSU op held by its queue for three cycles, new op waiting upstream.
    drive_op(1, 1, 43, 1, 1, 1, 44, 7, 1, 5);
    cycle();
    drive_op(1, 2, 1, 1, 2, 1, 45, 8, 1, 6); set_down(1, 3'b101);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t4_hold_tag", 64'(iq_rob_tag_o), 64'd5);
      chk("t4_hold_iqv", 64'(iq_valid_o), 64'b010);
      chk("t4_hold_ready", 64'(ren_ready_o), 64'd0);
    end
    set_down(1, 3'b111);
    cycle();
    chk("t4_next_tag", 64'(iq_rob_tag_o), 64'd6);

    // Stalled BR entry squashed by recovery while fire would be possible.
    drive_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); set_down(1, 3'b011);
    cycle();
    chk("t5_br_iqv", 64'(iq_valid_o), 64'b100);
    recover_i = 1'b1; set_down(1, 3'b111);
    drive_op(1, 0, 3, 1, 4, 1, 46, 9, 1, 7);
    cycle();
    chk("t5_recover_ready", 64'(ren_ready_o), 64'd0);
    chk("t5_squashed", 64'(rob_valid_o), 64'd0);
    recover_i = 1'b0;

    // Destination preg 0 never becomes busy; fu_type 3 routes to ALU.
    drive_op(1, 0, 1, 1, 2, 1, 0, 9, 1, 8);
    cycle();
    drive_op(1, 3, 0, 1, 0, 1, 46, 10, 1, 9);
    cycle();
    chk("t6_ill_iqv", 64'(iq_valid_o), 64'b001);
    chk("t6_p0_rs1_rdy", 64'(iq_rs1_rdy_o), 64'd1);
    chk("t6_p0_rs2_rdy", 64'(iq_rs2_rdy_o), 64'd1);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      rst       = ($urandom_range(0, 149) == 0);
      recover_i = ($urandom_range(0, 19) == 0);
      drive_op($urandom_range(0, 3) != 0, $urandom_range(0, 3),
               $urandom_range(0, 15), $urandom_range(0, 1),
               $urandom_range(0, 15), $urandom_range(0, 1),
               $urandom_range(0, 15), $urandom_range(0, 63),
               $urandom_range(0, 3) != 0, $urandom_range(0, 63));
      set_down($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7) | $urandom_range(0, 7)));
      set_wb(2'($urandom_range(0, 3)), $urandom_range(0, 15), $urandom_range(0, 15));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
